// File: rtl/l2_arb_pkg.sv
// Shared types and helpers for the L2 read-port arbiter.
//   state_e  : grant FSM state (idle or current grant owner)
//   owner_e  : requester identity, also used as the in-flight read tag
//   L2_ARB_MAX_BURST : default burst limit under round-robin
//   sat_inc  : saturating increment for counters up to 64 bits wide
package l2_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWei  = 2'd1,
    StAct  = 2'd2
  } state_e;

  typedef enum logic {
    OwnWei = 1'b0,
    OwnAct = 1'b1
  } owner_e;

  localparam int unsigned L2_ARB_MAX_BURST = 8;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/l2_arb_grant.sv
// Grant FSM for the L2 read port: tracks the current owner, the burst length
// and the last owner, and produces a combinational one-hot grant.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   prio_mode_i         : 0 = round-robin with bursts, 1 = weight always wins
//   wei_ready_i/act_ready_i : requests
//   wei_gnt_o/act_gnt_o : grants (never both, zero during reset)
module l2_arb_grant
  import l2_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = L2_ARB_MAX_BURST
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic prio_mode_i,
  input  logic wei_ready_i,
  input  logic act_ready_i,
  output logic wei_gnt_o,
  output logic act_gnt_o
);

  localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);

  state_e              state_q, state_d;
  owner_e              last_q, last_d;
  logic [BurstW-1:0]   cnt_q, cnt_d;

  logic                gnt_any;
  owner_e              gnt_own;
  logic                cont;
  logic                other_ready;
  logic [BurstW-1:0]   cnt_eff;

  always_comb begin
    gnt_any     = 1'b0;
    gnt_own     = OwnWei;
    cont        = 1'b0;
    other_ready = 1'b0;
    cnt_eff     = '0;
    state_d     = StIdle;
    cnt_d       = '0;
    last_d      = last_q;

    if (wei_ready_i && act_ready_i) begin
      gnt_any = 1'b1;
      case (state_q)
        StWei:   gnt_own = OwnWei;
        // Priority mode lets weight pre-empt an activation burst at once.
        StAct:   gnt_own = prio_mode_i ? OwnWei : OwnAct;
        default: gnt_own = (prio_mode_i || last_q == OwnAct) ? OwnWei : OwnAct;
      endcase
    end else if (wei_ready_i) begin
      gnt_any = 1'b1;
      gnt_own = OwnWei;
    end else if (act_ready_i) begin
      gnt_any = 1'b1;
      gnt_own = OwnAct;
    end

    // A beat by a new owner (from idle or a same-cycle hand-over) starts a fresh burst.
    cont    = (state_q == StWei && gnt_own == OwnWei) || (state_q == StAct && gnt_own == OwnAct);
    cnt_eff = cont ? cnt_q : '0;
    other_ready = (gnt_own == OwnWei) ? act_ready_i : wei_ready_i;

    if (gnt_any) begin
      last_d = gnt_own;
      if (!prio_mode_i && other_ready && cnt_eff == BurstLast) begin
        state_d = (gnt_own == OwnWei) ? StAct : StWei;
        cnt_d   = '0;
      end else begin
        state_d = (gnt_own == OwnWei) ? StWei : StAct;
        // Hold at the limit so a late-arriving competitor is served on the next beat.
        cnt_d   = (cnt_eff == BurstLast) ? cnt_eff : cnt_eff + 1'b1;
      end
    end

    wei_gnt_o = !rst_i && gnt_any && (gnt_own == OwnWei);
    act_gnt_o = !rst_i && gnt_any && (gnt_own == OwnAct);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= OwnAct;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/l2_read_arbiter.sv
// Shares the single synchronous-read L2 SRAM port between the weight-fetch and
// activation-fetch requesters. Adds region bases, tags each read with its
// owner and routes the returning beat one cycle later.
//   core_clk, rst            : clock, synchronous active-high reset
//   prio_mode                : 0 = round-robin bursts, 1 = weight first
//   wei_base, act_base       : region base offsets
//   {wei,act}_buf_read_*     : requester ports (ready/addr in, gnt/valid/data out)
//   l2_read_en/addr/data     : SRAM port, data valid one cycle after en
//   wei_beats, act_beats     : saturating served-beat counters
module l2_read_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_BURST = L2_ARB_MAX_BURST,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              core_clk,
  input  logic              rst,
  input  logic              prio_mode,
  input  logic [ADDR_W-1:0] wei_base,
  input  logic [ADDR_W-1:0] act_base,
  input  logic              wei_buf_read_ready,
  input  logic [ADDR_W-1:0] wei_buf_read_addr,
  output logic              wei_buf_read_gnt,
  output logic              wei_buf_read_valid,
  output logic [DATA_W-1:0] wei_buf_read_data,
  input  logic              act_buf_read_ready,
  input  logic [ADDR_W-1:0] act_buf_read_addr,
  output logic              act_buf_read_gnt,
  output logic              act_buf_read_valid,
  output logic [DATA_W-1:0] act_buf_read_data,
  output logic              l2_read_en,
  output logic [ADDR_W-1:0] l2_read_addr,
  input  logic [DATA_W-1:0] l2_read_data,
  output logic [CNT_W-1:0]  wei_beats,
  output logic [CNT_W-1:0]  act_beats
);

  logic              valid_q;
  owner_e            tag_q;
  logic [DATA_W-1:0] wei_hold_q, act_hold_q;
  logic [CNT_W-1:0]  wei_beats_q, wei_beats_d;
  logic [CNT_W-1:0]  act_beats_q, act_beats_d;

  l2_arb_grant #(
    .MAX_BURST(MAX_BURST)
  ) u_grant (
    .clk_i      (core_clk),
    .rst_i      (rst),
    .prio_mode_i(prio_mode),
    .wei_ready_i(wei_buf_read_ready),
    .act_ready_i(act_buf_read_ready),
    .wei_gnt_o  (wei_buf_read_gnt),
    .act_gnt_o  (act_buf_read_gnt)
  );

  always_comb begin
    l2_read_en   = wei_buf_read_gnt | act_buf_read_gnt;
    // Sum is truncated to ADDR_W; region wrap-around is intended.
    l2_read_addr = wei_buf_read_gnt ? (wei_base + wei_buf_read_addr)
                                    : (act_base + act_buf_read_addr);

    // A beat returning while rst is high is dropped.
    wei_buf_read_valid = !rst && valid_q && (tag_q == OwnWei);
    act_buf_read_valid = !rst && valid_q && (tag_q == OwnAct);
    wei_buf_read_data  = wei_buf_read_valid ? l2_read_data : wei_hold_q;
    act_buf_read_data  = act_buf_read_valid ? l2_read_data : act_hold_q;

    wei_beats_d = wei_buf_read_valid ? CNT_W'(sat_inc(64'(wei_beats_q), CNT_W)) : wei_beats_q;
    act_beats_d = act_buf_read_valid ? CNT_W'(sat_inc(64'(act_beats_q), CNT_W)) : act_beats_q;

    wei_beats = wei_beats_q;
    act_beats = act_beats_q;
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      tag_q       <= OwnWei;
      wei_hold_q  <= '0;
      act_hold_q  <= '0;
      wei_beats_q <= '0;
      act_beats_q <= '0;
    end else begin
      valid_q     <= l2_read_en;
      tag_q       <= act_buf_read_gnt ? OwnAct : OwnWei;
      if (wei_buf_read_valid) wei_hold_q <= l2_read_data;
      if (act_buf_read_valid) act_hold_q <= l2_read_data;
      wei_beats_q <= wei_beats_d;
      act_beats_q <= act_beats_d;
    end
  end

endmodule

// File: tb/tb_l2_read_arbiter.sv
module tb_l2_read_arbiter;

  localparam int DW = 64;
  localparam int AW = 12;
  localparam int MB = 8;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst, prio;
  logic [AW-1:0] wbase, abase;
  logic          wr, ar;
  logic [AW-1:0] waddr, aaddr;
  logic          wei_gnt, wei_valid, act_gnt, act_valid;
  logic [DW-1:0] wei_data, act_data;
  logic          l2_en;
  logic [AW-1:0] l2_addr;
  logic [DW-1:0] l2_data;
  logic [CW-1:0] wei_beats, act_beats;

  always #5 clk = ~clk;

  l2_read_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .CNT_W(CW)
  ) dut (
    .core_clk          (clk),
    .rst               (rst),
    .prio_mode         (prio),
    .wei_base          (wbase),
    .act_base          (abase),
    .wei_buf_read_ready(wr),
    .wei_buf_read_addr (waddr),
    .wei_buf_read_gnt  (wei_gnt),
    .wei_buf_read_valid(wei_valid),
    .wei_buf_read_data (wei_data),
    .act_buf_read_ready(ar),
    .act_buf_read_addr (aaddr),
    .act_buf_read_gnt  (act_gnt),
    .act_buf_read_valid(act_valid),
    .act_buf_read_data (act_data),
    .l2_read_en        (l2_en),
    .l2_read_addr      (l2_addr),
    .l2_read_data      (l2_data),
    .wei_beats         (wei_beats),
    .act_beats         (act_beats)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // SRAM contents as a fixed function of the physical row.
  function automatic logic [63:0] mem(input logic [AW-1:0] ad);
    return (64'(ad) * 64'h9E3779B97F4A7C15) ^ 64'hDEAD_BEEF_0000_0000;
  endfunction

  // Reference model: owner 0 = none, 1 = weight, 2 = activation.
  int            m_own = 0, m_run = 0, m_last = 2, m_prev_g = 0;
  logic [AW-1:0] m_prev_addr = '0;
  logic [63:0]   m_hold_w = '0, m_hold_a = '0;
  int            m_wb = 0, m_ab = 0;
  bit            seen_rst = 0;
  logic [AW-1:0] wa = '0, aa = '0;
  logic          d_en_prev = 1'b0;
  logic [AW-1:0] d_addr_prev = '0;
  int            n_wg = 0, n_ag = 0, n_none = 0;

  task automatic step(input bit r, input bit w, input bit a, input bit p);
    int            g;
    bit            wv, av, oth;
    logic [AW-1:0] ea;
    logic [63:0]   ewd, ead;
    @(negedge clk);
    rst = r; wr = w; ar = a; prio = p; waddr = wa; aaddr = aa;
    l2_data = d_en_prev ? mem(d_addr_prev) : {$urandom, $urandom};

    g = 0;
    if (!r) begin
      if (w && a) begin
        if (m_own == 1)      g = 1;
        else if (m_own == 2) g = p ? 1 : 2;
        else                 g = (p || m_last == 2) ? 1 : 2;
      end else if (w) g = 1;
      else if (a)     g = 2;
    end
    ea  = (g == 1) ? wbase + wa : abase + aa;
    wv  = !r && m_prev_g == 1;
    av  = !r && m_prev_g == 2;
    ewd = wv ? mem(m_prev_addr) : m_hold_w;
    ead = av ? mem(m_prev_addr) : m_hold_a;

    #1;
    check_eq("wei_gnt", 64'(wei_gnt), 64'(g == 1));
    check_eq("act_gnt", 64'(act_gnt), 64'(g == 2));
    check_eq("l2_en", 64'(l2_en), 64'(g != 0));
    if (g != 0) check_eq("l2_addr", 64'(l2_addr), 64'(ea));
    check_eq("wei_valid", 64'(wei_valid), 64'(wv));
    check_eq("act_valid", 64'(act_valid), 64'(av));
    if (seen_rst) begin
      check_eq("wei_data", wei_data, ewd);
      check_eq("act_data", act_data, ead);
      check_eq("wei_beats", 64'(wei_beats), 64'(m_wb));
      check_eq("act_beats", 64'(act_beats), 64'(m_ab));
    end
    n_wg   += int'(wei_gnt);
    n_ag   += int'(act_gnt);
    n_none += int'(!l2_en);
    d_en_prev   = l2_en;
    d_addr_prev = l2_addr;

    if (r) begin
      seen_rst = 1; m_own = 0; m_run = 0; m_last = 2; m_prev_g = 0;
      m_hold_w = '0; m_hold_a = '0; m_wb = 0; m_ab = 0;
    end else begin
      if (wv) m_hold_w = ewd;
      if (av) m_hold_a = ead;
      if (wv && m_wb < CMAX) m_wb++;
      if (av && m_ab < CMAX) m_ab++;
      if (g == 0) begin
        m_own = 0; m_run = 0;
      end else begin
        if (g != m_own) m_run = 0;
        oth = (g == 1) ? a : w;
        if (!p && oth && m_run >= MB - 1) begin
          m_own = 3 - g; m_run = 0;
        end else begin
          m_own = g; m_run++;
        end
        m_last = g;
      end
      if (g == 1) wa++;
      if (g == 2) aa++;
      m_prev_g = g; m_prev_addr = ea;
    end
  endtask

  logic [AW-1:0] wrap_exp [4];
  bit            rp;

  initial begin
    rst = 1'b1; prio = 1'b0; wr = 1'b0; ar = 1'b0; waddr = '0; aaddr = '0; l2_data = '0;
    wbase = '0; abase = 12'h800;
    wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h001;

    // Reset with both requests high: no grants.
    repeat (2) step(1, 1, 1, 0);

    // Weight only, five beats from base 0x100.
    wbase = 12'h100; wa = '0;
    repeat (5) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    check_eq("wei_beats_after_5", 64'(wei_beats), 64'd5);

    // Both ready, round-robin bursts: equal share, no idle cycle.
    n_wg = 0; n_ag = 0; n_none = 0;
    repeat (32) step(0, 1, 1, 0);
    check_eq("rr_wei_grants", 64'(n_wg), 64'd16);
    check_eq("rr_act_grants", 64'(n_ag), 64'd16);
    check_eq("rr_idle_cycles", 64'(n_none), 64'd0);

    // Weight priority.
    n_wg = 0; n_ag = 0;
    repeat (20) step(0, 1, 1, 1);
    check_eq("prio_wei_grants", 64'(n_wg), 64'd20);
    check_eq("prio_act_grants", 64'(n_ag), 64'd0);
    step(0, 0, 1, 1);
    check_eq("prio_act_after_drop", 64'(act_gnt), 64'd1);
    step(0, 0, 0, 0);

    // Activation address wrap.
    abase = 12'hFFE; aa = '0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      check_eq("wrap_addr", 64'(l2_addr), 64'(wrap_exp[i]));
    end
    step(0, 0, 0, 0);

    // Reset the cycle after a grant: the in-flight beat is dropped.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    check_eq("rst_inflight_valid", 64'(wei_valid), 64'd0);
    step(0, 0, 0, 0);
    check_eq("post_rst_valid", 64'(wei_valid), 64'd0);
    check_eq("post_rst_beats", 64'(wei_beats), 64'd0);
    step(0, 1, 1, 0);
    check_eq("post_rst_tie_wei", 64'(wei_gnt), 64'd1);
    step(0, 0, 0, 0);

    // Counter saturation at 2^CW-1.
    repeat (20) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    check_eq("wei_beats_sat", 64'(wei_beats), 64'(CMAX));

    // Random traffic.
    rp = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        wbase = AW'($urandom);
        abase = AW'($urandom);
      end
      if ($urandom_range(0, 99) == 0) rp = ~rp;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_read_arbiter.md
# l2_read_arbiter

Shares the single synchronous-read port of the L2 on-chip SRAM between the weight-fetch and activation-fetch requesters of DLA_CORE. The L2 weight and activation regions become one physical array at distinct base offsets. The block sits between DLA_CORE's `wei_buf_read_*` / `act_buf_read_*` ports and the L2 SRAM. It grants bursts round-robin or weight-first, adds region bases, and routes returning data with a `*_read_valid` strobe.

## Interface

Parameters:
- DATA_W, 64, L2 row width; both requesters use it.
- ADDR_W, 12, L2 physical address width.
- MAX_BURST, 8, maximum consecutive beats granted to one requester while the other is waiting.
- CNT_W, 16, width of the per-requester beat counters.

Ports:
- core_clk  in  1  sole clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- prio_mode  in  1  0 = round-robin with bursts, 1 = weight always wins; sampled every cycle.
- wei_base, act_base  in  ADDR_W  region base offsets; quasi-static.
- wei_buf_read_ready  in  1  weight request; the address is valid this cycle.
- wei_buf_read_addr  in  ADDR_W  weight row, relative to wei_base.
- wei_buf_read_gnt  out  1  address consumed this cycle.
- wei_buf_read_valid  out  1  data beat present.
- wei_buf_read_data  out  DATA_W  returned row.
- act_buf_read_ready, act_buf_read_addr, act_buf_read_gnt, act_buf_read_valid, act_buf_read_data: identical to the weight ports, for activations.
- l2_read_en  out  1  SRAM read strobe.
- l2_read_addr  out  ADDR_W  physical address.
- l2_read_data  in  DATA_W  SRAM output, valid one cycle after l2_read_en.
- wei_beats, act_beats  out  CNT_W  saturating counts of served beats.

## Operation

- States: IDLE, WEI, ACT. The state names the current grant owner.
- IDLE:
  - Only one requester ready: that requester is granted.
  - Both ready: WEI is granted if prio_mode=1 or the last owner was ACT; otherwise ACT is granted.
- WEI / ACT, while the owner keeps `*_ready` high:
  - The owner is granted every cycle.
  - burst_cnt increments on each owner beat.
  - The state switches to the other requester when burst_cnt==MAX_BURST−1 on a granted beat and the other requester is ready and prio_mode=0. burst_cnt resets to 0 on the switch.
- Owner drops `*_ready`:
  - Other requester ready: switch to it in the same cycle (combinational grant).
  - Neither ready: go to IDLE.
- With prio_mode=1, WEI is never pre-empted by the burst limit. ACT is pre-empted whenever wei_buf_read_ready=1.
- Grant decision is combinational from the current state and both ready signals. Exactly one `*_gnt` is high at a time, never both.
- l2_read_en = wei_gnt | act_gnt.
- l2_read_addr = base + req_addr, truncated to ADDR_W. Wrap-around is legal and intended.
- A 1-bit in-flight tag register records which requester owns each read. Returning data goes to the tagged requester's `*_read_data`; the other requester's `*_read_data` holds its last value.
- Beat counters increment on each `*_read_valid`. They saturate at 2^CNT_W−1 and do not wrap.

## Timing

- Cycle t: `*_gnt`=1, l2_read_en=1. The requester advances its address after a cycle with gnt=1.
- Cycle t+1: `*_read_valid`=1 and `*_read_data` = l2_read_data. Latency is 1 cycle and throughput is 1 beat per cycle.
- A switch between owners adds no bubble. Back-to-back beats of different owners return in issue order.
- Reset values:
  - state=IDLE, burst_cnt=0, last owner=ACT (so WEI wins the first tie).
  - Both `*_read_valid`=0, `*_read_data`=0, counters=0.
  - Grants are 0 during reset regardless of the ready inputs.
- rst asserted with a read in flight: valid is forced to 0 on the next edge and the returning beat is discarded.
- Both requesters rising in the same cycle from IDLE: the tie-break rule above applies.
- `*_read_ready` deasserting in the cycle after a grant does not cancel the in-flight beat. It still returns.

## Structure

- Package l2_arb_pkg holds:
  - the state enum (IDLE, WEI, ACT);
  - the owner type (OWN_WEI=0, OWN_ACT=1);
  - default MAX_BURST;
  - the saturating-increment function.
- Sub-module l2_arb_grant holds the FSM, burst counter and combinational grant logic.
- The top level holds the address adders, the in-flight tag, the data routing and the beat counters.

## Test plan

- Weight only: wei ready for 5 cycles, addr 0..4, wei_base=0x100 → l2_read_addr 0x100..0x104 on consecutive cycles; wei valid cycles 1..5 later with the matching rows; wei_beats=5.
- Both ready continuously, MAX_BURST=8, prio_mode=0 → grant pattern 8×WEI, 8×ACT, repeating; no idle cycle; data routed by tag.
- prio_mode=1, both ready for 20 cycles → 20 WEI grants, 0 ACT grants; ACT is granted the cycle after wei ready drops.
- act_base=0xFFE, act addr 0..3 → physical addresses 0xFFE, 0xFFF, 0x000, 0x001.
- rst asserted the cycle after a grant → no `*_read_valid`; state IDLE; counters 0; the first tie after reset goes to WEI.
- Counter saturation with CNT_W=4: 20 weight beats → wei_beats holds 15.
